// File: rtl/axi_tdd_ng_cfg_loader.sv
// Purpose : up-bus initiator that programs the TDD-NG regmap from a {addr, data, last} command stream,
//           polling the TDD status register until IDLE before the first write of each sequence.
// Latency : one poll round trip before the first write, then >= 3 cycles per entry (accept, write, ack).
// Backpressure: cmd_ready is high only in ACCEPT/DRAIN; a stalled cmd_valid in ACCEPT waits forever.
// Ports   : up_clk/up_rstn; cmd_* command stream (valid/ready); up_w*/up_r* single-pulse request bus
//           with up_wack/up_rack responses; busy/done/error/err_code sequence status.
// Option  : define AXI_TDD_NG_CFG_VERIFY_EN to read back and compare every written register.
module axi_tdd_ng_cfg_loader #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 'h18,
    parameter int                    POLL_LIMIT  = 1024,
    parameter int                    ACK_TIMEOUT = 255
) (
    input  logic                  up_clk,
    input  logic                  up_rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_data,
    input  logic                  cmd_last,
    output logic                  up_wreq,
    output logic [ADDR_WIDTH-1:0] up_waddr,
    output logic [31:0]           up_wdata,
    input  logic                  up_wack,
    output logic                  up_rreq,
    output logic [ADDR_WIDTH-1:0] up_raddr,
    input  logic [31:0]           up_rdata,
    input  logic                  up_rack,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL_REQ,
        S_POLL_WAIT,
        S_ACCEPT,
        S_WRITE,
        S_WACK,
`ifdef AXI_TDD_NG_CFG_VERIFY_EN
        S_DRAIN,
        S_VREQ,
        S_VWAIT
`else
        S_DRAIN
`endif
    } state_t;

    localparam logic [15:0] POLL_LIM = 16'(POLL_LIMIT);
    // Wait states count 0..ACK_TIMEOUT-1; the last value is the expiry cycle.
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

    localparam logic [1:0] ERR_POLL   = 2'd1;
    localparam logic [1:0] ERR_ACK    = 2'd2;
`ifdef AXI_TDD_NG_CFG_VERIFY_EN
    localparam logic [1:0] ERR_VERIFY = 2'd3;
`endif

    state_t      state;
    logic [15:0] poll_cnt;
    logic [15:0] tmo_cnt;
    logic        last_q;
    logic        tmo_hit;

    assign tmo_hit   = (tmo_cnt == ACK_LAST);
    assign cmd_ready = (state == S_ACCEPT) || (state == S_DRAIN);

`ifndef AXI_TDD_NG_CFG_VERIFY_EN
    // Only the state field of the status word matters without readback compare.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^up_rdata[31:2];
`endif

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state    <= S_IDLE;
            poll_cnt <= '0;
            tmo_cnt  <= '0;
            last_q   <= 1'b0;
            up_wreq  <= 1'b0;
            up_waddr <= '0;
            up_wdata <= '0;
            up_rreq  <= 1'b0;
            up_raddr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
        end else begin
            // Request and done strobes are single-cycle unless re-armed below.
            up_wreq <= 1'b0;
            up_rreq <= 1'b0;
            done    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state    <= S_POLL_REQ;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        err_code <= 2'd0;
                        poll_cnt <= '0;
                        up_rreq  <= 1'b1;
                        up_raddr <= STATUS_ADDR;
                    end
                end

                S_POLL_REQ: begin
                    state   <= S_POLL_WAIT;
                    tmo_cnt <= '0;
                end

                S_POLL_WAIT: begin
                    // An ack on the expiry cycle wins over the timeout.
                    if (up_rack) begin
                        if (up_rdata[1:0] == 2'b00) begin
                            state <= S_ACCEPT;
                        end else if (poll_cnt + 16'd1 == POLL_LIM) begin
                            error    <= 1'b1;
                            err_code <= ERR_POLL;
                            state    <= S_DRAIN;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                            up_rreq  <= 1'b1;
                            state    <= S_POLL_REQ;
                        end
                    end else if (tmo_hit) begin
                        error    <= 1'b1;
                        err_code <= ERR_ACK;
                        state    <= S_DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                S_ACCEPT: begin
                    // cmd_ready is high here, so valid alone completes the handshake.
                    if (cmd_valid) begin
                        up_waddr <= cmd_addr;
                        up_wdata <= cmd_data;
                        last_q   <= cmd_last;
                        up_wreq  <= 1'b1;
                        state    <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    state   <= S_WACK;
                    tmo_cnt <= '0;
                end

                S_WACK: begin
                    if (up_wack) begin
`ifdef AXI_TDD_NG_CFG_VERIFY_EN
                        up_rreq  <= 1'b1;
                        up_raddr <= up_waddr;
                        state    <= S_VREQ;
`else
                        if (last_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_ACCEPT;
                        end
`endif
                    end else if (tmo_hit) begin
                        error    <= 1'b1;
                        err_code <= ERR_ACK;
                        // Nothing left to drain if the stuck entry closed the sequence.
                        if (last_q) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                S_DRAIN: begin
                    if (cmd_valid && cmd_last) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

`ifdef AXI_TDD_NG_CFG_VERIFY_EN
                S_VREQ: begin
                    state   <= S_VWAIT;
                    tmo_cnt <= '0;
                end

                S_VWAIT: begin
                    if (up_rack && (up_rdata == up_wdata)) begin
                        if (last_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_ACCEPT;
                        end
                    end else if (up_rack || tmo_hit) begin
                        error    <= 1'b1;
                        err_code <= up_rack ? ERR_VERIFY : ERR_ACK;
                        if (last_q) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
`endif

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_tdd_ng_cfg_loader.sv
// Bench for axi_tdd_ng_cfg_loader: vector table plus randomized sequences checked against a
// sequence-level model, with a behavioural regmap responder and hand-written reset/timing cases.
module tb_axi_tdd_ng_cfg_loader;

    localparam int          AW   = 8;
    localparam int          PL   = 4;
    localparam int          AT   = 8;
    localparam logic [7:0]  STAT = 8'h18;
`ifdef AXI_TDD_NG_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic          up_clk = 1'b0;
    logic          up_rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_data = '0;
    logic          cmd_last = 1'b0;
    logic          up_wreq;
    logic [AW-1:0] up_waddr;
    logic [31:0]   up_wdata;
    logic          up_wack;
    logic          up_rreq;
    logic [AW-1:0] up_raddr;
    logic [31:0]   up_rdata;
    logic          up_rack;
    logic          busy, done, error;
    logic [1:0]    err_code;

    always #5 up_clk = ~up_clk;

    axi_tdd_ng_cfg_loader #(
        .ADDR_WIDTH (AW),
        .STATUS_ADDR(STAT),
        .POLL_LIMIT (PL),
        .ACK_TIMEOUT(AT)
    ) dut (
        .up_clk   (up_clk),
        .up_rstn  (up_rstn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_last (cmd_last),
        .up_wreq  (up_wreq),
        .up_waddr (up_waddr),
        .up_wdata (up_wdata),
        .up_wack  (up_wack),
        .up_rreq  (up_rreq),
        .up_raddr (up_raddr),
        .up_rdata (up_rdata),
        .up_rack  (up_rack),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- regmap responder ----------------
    logic [31:0] stat_q[$];
    logic [7:0]  wlog_a[$];
    logic [31:0] wlog_d[$];
    logic [31:0] mem[256];
    logic [31:0] rnext;
    int stat_reads, w_idx, v_idx, withhold_idx, corrupt_idx;
    int wack_delay, rack_delay, wpend, rpend;
    int cyc, wreq_cyc, err_cyc, done_cnt;
    bit late_wack, err_prev;

    initial begin : responder
        up_wack = 1'b0; up_rack = 1'b0; up_rdata = '0; rnext = '0;
        wpend = 0; rpend = 0; cyc = 0; wreq_cyc = 0; err_cyc = -1; err_prev = 1'b0;
        done_cnt = 0; late_wack = 1'b0; withhold_idx = -1; corrupt_idx = -1;
        wack_delay = 0; rack_delay = 0; stat_reads = 0; w_idx = 0; v_idx = 0;
        forever begin
            @(posedge up_clk); #1;
            cyc++;
            up_wack = late_wack;
            up_rack = 1'b0;
            if (!up_rstn) begin
                wpend = 0; rpend = 0;
            end else begin
                if (wpend > 0) begin wpend--; if (wpend == 0) up_wack = 1'b1; end
                if (rpend > 0) begin
                    rpend--;
                    if (rpend == 0) begin up_rack = 1'b1; up_rdata = rnext; end
                end
                if (up_wreq) begin
                    wlog_a.push_back(up_waddr);
                    wlog_d.push_back(up_wdata);
                    mem[up_waddr] = up_wdata;
                    wreq_cyc = cyc;
                    if (w_idx != withhold_idx) wpend = 1 + wack_delay;
                    w_idx++;
                end
                if (up_rreq) begin
                    if (up_raddr == STAT) begin
                        stat_reads++;
                        rnext = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
                    end else begin
                        rnext = mem[up_raddr];
                        if (v_idx == corrupt_idx) rnext = rnext ^ 32'h1;
                        v_idx++;
                    end
                    rpend = 1 + rack_delay;
                end
                if (done) done_cnt++;
                if (error && !err_prev && err_cyc < 0) err_cyc = cyc;
            end
            err_prev = error;
        end
    end

    // ---------------- vectors and model ----------------
    typedef struct {
        int n; int nz; logic [31:0] sv;
        int wh; int wdly; int rdly; int cor;
        logic [4:0][7:0]  a;
        logic [4:0][31:0] d;
        int e_reads; int e_writes; int e_done; int e_code;
    } vec_t;

    function automatic vec_t mk(int n, int nz, int sv, int wh, int wdly, int rdly, int cor,
                                int er, int ew, int ed, int ec);
        vec_t v;
        v.n = n; v.nz = nz; v.sv = 32'(sv); v.wh = wh; v.wdly = wdly; v.rdly = rdly; v.cor = cor;
        v.a = {8'h12, 8'h13, 8'h10, 8'h11, 8'h15};
        v.d = {32'hAA, 32'h55, 32'h1, 32'h3, 32'h100};
        v.e_reads = er; v.e_writes = ew; v.e_done = ed; v.e_code = ec;
        return v;
    endfunction

    // Sequence-level outcome from the poll/ack/verify rules.
    task automatic model(input vec_t v, output int er, output int ew, output int ed, output int ec);
        ec = 0; ew = 0;
        if (v.rdly >= AT) begin
            er = 1; ec = 2;
        end else if (v.nz >= PL) begin
            er = PL; ec = 1;
        end else begin
            er = v.nz + 1;
            ew = v.n;
            for (int i = 0; i < v.n; i++) begin
                if (i == v.wh || v.wdly >= AT) begin ew = i + 1; ec = 2; break; end
                if (VERIFY && i == v.cor) begin ew = i + 1; ec = 3; break; end
            end
        end
        ed = (ec == 0) ? 1 : 0;
    endtask

    task automatic run_vec(input vec_t v, input string nm, input int gap);
        bit ok;
        stat_q.delete();
        for (int i = 0; i < v.nz; i++) stat_q.push_back(v.sv);
        wlog_a.delete(); wlog_d.delete();
        stat_reads = 0; w_idx = 0; v_idx = 0; done_cnt = 0; err_cyc = -1;
        withhold_idx = v.wh; wack_delay = v.wdly; rack_delay = v.rdly; corrupt_idx = v.cor;
        for (int i = 0; i < v.n; i++) begin
            cmd_valid = 1'b1; cmd_addr = v.a[i]; cmd_data = v.d[i]; cmd_last = (i == v.n - 1);
            ok = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge up_clk);
                if (cmd_ready) begin ok = 1'b1; break; end
            end
            @(posedge up_clk); #1;
            cmd_valid = 1'b0;
            if (!ok) begin check({nm, " accept_budget"}, 0, 1); break; end
            repeat ($urandom_range(0, gap)) begin @(posedge up_clk); #1; end
        end
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge up_clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        check({nm, " busy_fall"}, 64'(ok), 1);
        repeat (3) @(posedge up_clk); #1;
        check({nm, " status_reads"}, 64'(stat_reads), 64'(v.e_reads));
        check({nm, " writes"}, 64'(wlog_a.size()), 64'(v.e_writes));
        for (int i = 0; i < v.e_writes && i < wlog_a.size(); i++) begin
            check($sformatf("%s waddr%0d", nm, i), 64'(wlog_a[i]), 64'(v.a[i]));
            check($sformatf("%s wdata%0d", nm, i), 64'(wlog_d[i]), 64'(v.d[i]));
        end
        check({nm, " done_pulses"}, 64'(done_cnt), 64'(v.e_done));
        check({nm, " error"}, 64'(error), 64'(v.e_code != 0));
        check({nm, " err_code"}, 64'(err_code), 64'(v.e_code));
    endtask

    function automatic logic [55:0] outs();
        return {busy, done, error, err_code, up_wreq, up_rreq, cmd_ready, up_waddr, up_wdata, up_raddr};
    endfunction

    vec_t tbl[$];

    initial begin : main
        vec_t v;
        int er, ew, ed, ec;
        bit ok;

        //        n  nz sv wh wdly rdly cor  reads wr done code
        tbl.push_back(mk(3, 0, 0, -1, 0, 0, -1, 1, 3, 1, 0));  // idle on first poll
        tbl.push_back(mk(3, 2, 3, -1, 0, 0, -1, 3, 3, 1, 0));  // RUNNING twice then idle
        tbl.push_back(mk(5, 9, 1, -1, 0, 0, -1, 4, 0, 0, 1));  // poll limit, 5 entries drained
        tbl.push_back(mk(3, 0, 0,  1, 0, 0, -1, 1, 2, 0, 2));  // wack withheld on entry 2 of 3
        tbl.push_back(mk(3, 3, 2, -1, 0, 0, -1, 4, 3, 1, 0));  // idle on the last allowed poll
        tbl.push_back(mk(3, 0, 0,  2, 0, 0, -1, 1, 3, 0, 2));  // wack withheld on last entry
        tbl.push_back(mk(2, 0, 0, -1, 7, 0, -1, 1, 2, 1, 0));  // wack on expiry cycle is success
        tbl.push_back(mk(2, 0, 0, -1, 8, 0, -1, 1, 1, 0, 2));  // wack one cycle too late
        tbl.push_back(mk(1, 0, 0, -1, 0, 7, -1, 1, 1, 1, 0));  // rack on expiry cycle
        tbl.push_back(mk(2, 0, 0, -1, 0, 8, -1, 1, 0, 0, 2));  // poll rack timeout
`ifdef AXI_TDD_NG_CFG_VERIFY_EN
        v = mk(1, 0, 0, -1, 0, 0, 0, 1, 1, 0, 3);
        v.a[0] = 8'h14; v.d[0] = 32'hABCD;
        tbl.push_back(v);                                      // readback 0xABCC mismatch
        v.cor = -1; v.e_done = 1; v.e_code = 0;
        tbl.push_back(v);                                      // matching readback
`endif

        // Reset state.
        repeat (2) @(posedge up_clk); #1;
        check("reset_outputs", outs(), '0);
        @(negedge up_clk); up_rstn = 1'b1;
        repeat (2) @(posedge up_clk); #1;
        check("idle_after_reset", outs(), '0);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i), 0);

        // Ack timeout fires ACK_TIMEOUT wait cycles after the request cycle.
        run_vec(tbl[3], "tmo_timing", 0);
        check("tmo_timing err_delay", 64'(err_cyc - wreq_cyc), 64'(AT + 1));

        // Reset while waiting for a withheld wack, then a late wack.
        stat_q.delete(); wlog_a.delete(); wlog_d.delete();
        w_idx = 0; withhold_idx = 0; wack_delay = 0; rack_delay = 0; done_cnt = 0;
        cmd_valid = 1'b1; cmd_addr = 8'h15; cmd_data = 32'h100; cmd_last = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge up_clk); #2;
            if (wlog_a.size() == 1) begin ok = 1'b1; break; end
        end
        check("rst_reached_wack", 64'(ok), 1);
        cmd_valid = 1'b0;
        @(posedge up_clk); #1;
        check("rst_busy_before", 64'(busy), 1);
        @(negedge up_clk); up_rstn = 1'b0;
        #1;
        check("rst_mid_outputs", outs(), '0);
        repeat (2) @(posedge up_clk);
        @(negedge up_clk); up_rstn = 1'b1;
        @(negedge up_clk); late_wack = 1'b1;
        @(negedge up_clk); late_wack = 1'b0;
        repeat (3) @(posedge up_clk); #1;
        check("rst_late_ack_outputs", outs(), '0);
        check("rst_late_ack_done", 64'(done_cnt), 0);
        run_vec(tbl[0], "after_reset", 0);

        // Randomized sequences against the model.
        for (int t = 0; t < 30; t++) begin
            v = mk(1, 0, 0, -1, 0, 0, -1, 0, 0, 0, 0);
            v.n = $urandom_range(1, 5);
            v.nz = ($urandom_range(0, 3) == 0) ? $urandom_range(PL, PL + 2) : $urandom_range(0, PL - 1);
            v.sv = 32'($urandom_range(1, 3)) | {$urandom, 2'b00};
            v.wh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v.n - 1) : -1;
            v.wdly = $urandom_range(0, 3);
            v.rdly = $urandom_range(0, 2);
            v.cor = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v.n - 1) : -1;
            for (int i = 0; i < 5; i++) begin
                v.a[i] = 8'($urandom_range(0, 255));
                if (v.a[i] == STAT) v.a[i] = 8'h19;
                v.d[i] = $urandom;
            end
            model(v, er, ew, ed, ec);
            v.e_reads = er; v.e_writes = ew; v.e_done = ed; v.e_code = ec;
            run_vec(v, $sformatf("rnd%0d", t), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
